// File: rtl/vga_pkg.sv
// vga_pkg: pattern mode encodings, colour-bar table and 800x600@60 timing defaults
package vga_pkg;
    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;
    localparam int DEF_H_SYNC = 128;
    localparam int DEF_H_BP   = 88;
    localparam int DEF_H_ACT  = 800;
    localparam int DEF_H_FP   = 40;
    localparam int DEF_V_SYNC = 4;
    localparam int DEF_V_BP   = 23;
    localparam int DEF_V_ACT  = 600;
    localparam int DEF_V_FP   = 1;
    // {R,G,B} on/off per bar; bar 0 (white) sits in the low bits
    localparam logic [23:0] BAR_TABLE = {3'b000, 3'b001, 3'b100, 3'b101,
                                         3'b010, 3'b011, 3'b110, 3'b111};
    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        return BAR_TABLE[idx*3 +: 3];
    endfunction
endpackage

// File: rtl/vga_timing_core.sv
// vga_timing_core: h/v counters with registered sync, data-enable, x/y and frame_start.
// Also exposes the unregistered pixel state so the pattern logic can register in step.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    output logic                       de_d,
    output logic [$clog2(H_ACT)-1:0]   x_d,
    output logic [$clog2(V_ACT)-1:0]   y_d,
    output logic                       first,
    output logic                       last,
    output logic                       vga_hs,
    output logic                       vga_vs,
    output logic                       vga_de,
    output logic [$clog2(H_ACT)-1:0]   vga_x,
    output logic [$clog2(V_ACT)-1:0]   vga_y,
    output logic                       frame_start
);
    localparam int XW = $clog2(H_ACT);
    localparam int YW = $clog2(V_ACT);
    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HW = $clog2(H_TOT);
    localparam int VW = $clog2(V_TOT);
    localparam logic [HW-1:0] H_SEND  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_START = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_END   = HW'(H_SYNC + H_BP + H_ACT);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_SEND  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_START = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_END   = VW'(V_SYNC + V_BP + V_ACT);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, fs_q, fs_d, h_last, v_last;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    always_comb begin
        h_last  = h_cnt_q == H_LAST;
        v_last  = v_cnt_q == V_LAST;
        de_d    = en && h_cnt_q >= H_START && h_cnt_q < H_END && v_cnt_q >= V_START && v_cnt_q < V_END;
        x_d     = de_d ? XW'(h_cnt_q - H_START) : '0;
        y_d     = de_d ? YW'(v_cnt_q - V_START) : '0;
        first   = h_cnt_q == '0 && v_cnt_q == '0;
        last    = h_last && v_last;
        h_cnt_d = !en ? h_cnt_q : h_last ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = !(en && h_last) ? v_cnt_q : v_last ? '0 : v_cnt_q + VW'(1);
        // a disabled source drives idle syncs rather than freezing them mid-pulse
        hs_d    = en && h_cnt_q < H_SEND ? HS_POL : ~HS_POL;
        vs_d    = en && v_cnt_q < V_SEND ? VS_POL : ~VS_POL;
        fs_d    = en && first;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign vga_x       = x_q;
    assign vga_y       = y_q;
    assign frame_start = fs_q;
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing plus a runtime-selectable solid / bars / checker / bouncing-box pattern.
// Mode and colour are latched at the frame origin so a frame never tears.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int H_ACT     = DEF_H_ACT,
    parameter int H_FP      = DEF_H_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int V_ACT     = DEF_V_ACT,
    parameter int V_FP      = DEF_V_FP,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int R_W       = 3,
    parameter int G_W       = 3,
    parameter int B_W       = 2,
    parameter int CELL_LOG2 = 5,
    parameter int BOX_SIZE  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [R_W+G_W+B_W-1:0]       solid_rgb,
    output logic                         vga_hs,
    output logic                         vga_vs,
    output logic                         vga_de,
    output logic [$clog2(H_ACT)-1:0]     vga_x,
    output logic [$clog2(V_ACT)-1:0]     vga_y,
    output logic [R_W+G_W+B_W-1:0]       vga_rgb,
    output logic                         frame_start
);
    localparam int XW    = $clog2(H_ACT);
    localparam int YW    = $clog2(V_ACT);
    localparam int CW    = R_W + G_W + B_W;
    localparam int BAR_W = H_ACT / 8;
    localparam int BW    = $clog2(BAR_W + 1);
    localparam logic [XW-1:0] BX_MAX   = XW'(H_ACT - BOX_SIZE);
    localparam logic [YW-1:0] BY_MAX   = YW'(V_ACT - BOX_SIZE);
    localparam logic [XW-1:0] BOX_X    = XW'(BOX_SIZE);
    localparam logic [YW-1:0] BOX_Y    = YW'(BOX_SIZE);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    if (H_SYNC <= 0 || H_BP <= 0 || H_ACT <= 0 || H_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
        V_ACT <= 0 || V_FP <= 0 || BOX_SIZE <= 0 || BOX_SIZE >= H_ACT || BOX_SIZE >= V_ACT ||
        H_ACT % 8 != 0 || CELL_LOG2 >= XW || CELL_LOG2 >= YW) begin : g_bad_params
        $error("vga_pattern_gen: invalid segment, bar, cell or box parameters");
    end

    logic          de_d, first, last, upd, in_box, chk, bar_end, dx_q, dx_d, dy_q, dy_d;
    logic [XW-1:0] x_d, bx_q, bx_d;
    logic [YW-1:0] y_d, by_q, by_d;
    logic [CW-1:0] rgb_q, rgb_d, pix_q, pix_d, bar_rgb;
    logic [2:0]    bar, bar_idx_q, bar_idx_d;
    logic [BW-1:0] bar_px_q, bar_px_d;
    mode_e         mode_q, mode_d;

    vga_timing_core #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .en(en),
        .de_d(de_d), .x_d(x_d), .y_d(y_d), .first(first), .last(last),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_x(vga_x), .vga_y(vga_y), .frame_start(frame_start)
    );

    always_comb begin
        mode_d    = en && first ? mode_e'(mode) : mode_q;
        rgb_d     = en && first ? solid_rgb : rgb_q;
        bar_end   = bar_px_q == BAR_LAST;
        bar_px_d  = !en ? bar_px_q : !de_d || bar_end ? '0 : bar_px_q + BW'(1);
        bar_idx_d = !en ? bar_idx_q : !de_d ? '0 : bar_idx_q + {2'b00, bar_end};
        // a bounce flips direction and steps back in the same update, so the box never pauses
        upd       = en && last;
        dx_d      = upd && (dx_q ? bx_q == BX_MAX : bx_q == '0) ? ~dx_q : dx_q;
        dy_d      = upd && (dy_q ? by_q == BY_MAX : by_q == '0) ? ~dy_q : dy_q;
        bx_d      = !upd ? bx_q : dx_d ? bx_q + XW'(1) : bx_q - XW'(1);
        by_d      = !upd ? by_q : dy_d ? by_q + YW'(1) : by_q - YW'(1);
        bar       = bar_colour(bar_idx_q);
        bar_rgb   = {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}};
        chk       = x_d[CELL_LOG2] ^ y_d[CELL_LOG2];
        in_box    = x_d >= bx_q && x_d - bx_q < BOX_X && y_d >= by_q && y_d - by_q < BOX_Y;
        pix_d     = !de_d ? '0
                  : mode_q == MODE_SOLID ? rgb_q
                  : mode_q == MODE_BARS ? bar_rgb
                  : (mode_q == MODE_CHECK ? chk : in_box) ? rgb_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= MODE_SOLID;
            rgb_q     <= '0;
            pix_q     <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
        end else begin
            mode_q    <= mode_d;
            rgb_q     <= rgb_d;
            pix_q     <= pix_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
        end
    end

    assign vga_rgb = pix_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: three instances (defaults, default-H short-V checker, tiny box) on one clock.
module tb_vga_pattern_gen;
    import vga_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { int x; int y; logic [7:0] rgb; } pix_t;
    pix_t bar_tbl[11];
    pix_t chk_tbl[7];
    logic [7:0] d_line [800];
    logic [7:0] c_frame [40][800];

    logic       d_rst_n, d_en, d_hs, d_vs, d_de, d_fs;
    logic [1:0] d_mode;
    logic [7:0] d_solid, d_rgb;
    logic [9:0] d_x, d_y;
    logic       c_rst_n, c_en, c_hs, c_vs, c_de, c_fs;
    logic [1:0] c_mode;
    logic [7:0] c_solid, c_rgb;
    logic [9:0] c_x;
    logic [5:0] c_y;
    logic       s_rst_n, s_en, s_hs, s_vs, s_de, s_fs;
    logic [1:0] s_mode;
    logic [7:0] s_solid, s_rgb;
    logic [3:0] s_x, s_y;

    vga_pattern_gen u_def (
        .clk(clk), .rst_n(d_rst_n), .en(d_en), .mode(d_mode), .solid_rgb(d_solid),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de), .vga_x(d_x), .vga_y(d_y),
        .vga_rgb(d_rgb), .frame_start(d_fs)
    );

    vga_pattern_gen #(.V_SYNC(1), .V_BP(1), .V_ACT(40), .V_FP(1), .BOX_SIZE(16)) u_chk (
        .clk(clk), .rst_n(c_rst_n), .en(c_en), .mode(c_mode), .solid_rgb(c_solid),
        .vga_hs(c_hs), .vga_vs(c_vs), .vga_de(c_de), .vga_x(c_x), .vga_y(c_y),
        .vga_rgb(c_rgb), .frame_start(c_fs)
    );

    vga_pattern_gen #(.H_SYNC(2), .H_BP(2), .H_ACT(16), .H_FP(2), .V_SYNC(1), .V_BP(1),
                      .V_ACT(12), .V_FP(1), .CELL_LOG2(2), .BOX_SIZE(4)) u_sm (
        .clk(clk), .rst_n(s_rst_n), .en(s_en), .mode(s_mode), .solid_rgb(s_solid),
        .vga_hs(s_hs), .vga_vs(s_vs), .vga_de(s_de), .vga_x(s_x), .vga_y(s_y),
        .vga_rgb(s_rgb), .frame_start(s_fs)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic run_def();
        int hs_low = 0, vs_low = 0, vs_rise = -1, de_pre = 0, de_line = 0, first_de = -1;
        int fs_cnt = 0, xy_bad = 0, frz_bad = 0, fall = -1;
        int hs_fall[$];
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        d_rst_n = 1'b0; d_en = 1'b1; d_mode = 2'd1; d_solid = 8'h00;
        repeat (3) @(negedge clk);
        check("def reset outputs", {d_hs, d_vs, d_de, d_x, d_y, d_rgb, d_fs},
              {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 8'd0, 1'b0});
        d_rst_n = 1'b1;
        for (int n = 0; n < 28 * 1056; n++) begin
            @(negedge clk);
            if (n == 0) check("def frame_start first", {d_fs, d_hs, d_vs}, 3'b100);
            if (n < 1056 && !d_hs) hs_low++;
            if (prev_hs && !d_hs) hs_fall.push_back(n);
            if (!d_vs) vs_low++;
            if (!prev_vs && d_vs && vs_rise < 0) vs_rise = n;
            if (d_fs) fs_cnt++;
            if (d_de) begin
                if (n < 27 * 1056) de_pre++;
                else begin
                    de_line++;
                    if (first_de < 0) first_de = n;
                    d_line[d_x] = d_rgb;
                    if (int'(d_x) != n - 27 * 1056 - 216 || d_y != 10'd0) xy_bad++;
                end
            end
            prev_hs = d_hs;
            prev_vs = d_vs;
        end
        check("def hs low per line", hs_low, 128);
        check("def hs period", hs_fall.size() > 2 ? {hs_fall[1] - hs_fall[0], hs_fall[2] - hs_fall[1]} : 0,
              {32'd1056, 32'd1056});
        check("def hs pulses", hs_fall.size(), 28);
        check("def vs low", {vs_low, vs_rise}, {32'd4224, 32'd4224});
        check("def de in blanking", de_pre, 0);
        check("def de per line", {de_line, first_de}, {32'd800, 32'd28728});
        check("def x y on first line", xy_bad, 0);
        check("def frame_start count", fs_cnt, 1);
        repeat (501) @(negedge clk);
        check("def pixel h500 v28", {d_de, d_x, d_y}, {1'b1, 10'd284, 10'd1});
        d_rst_n = 1'b0;
        @(negedge clk);
        check("def midframe reset", {d_hs, d_vs, d_de, d_x, d_y, d_rgb, d_fs},
              {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 8'd0, 1'b0});
        repeat (2) @(negedge clk);
        d_rst_n = 1'b1;
        @(negedge clk);
        check("def frame_start after release", {d_fs, d_hs, d_vs, d_de}, 4'b1000);
        repeat (300) @(negedge clk);
        d_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!d_hs || !d_vs || d_de || d_fs || d_rgb != 8'd0) frz_bad++;
        end
        check("def outputs while disabled", frz_bad, 0);
        d_en = 1'b1;
        prev_hs = 1'b1;
        for (int n = 351; n < 2400 && fall < 0; n++) begin
            @(negedge clk);
            if (n == 351) check("def resume h301", {d_hs, d_vs}, 2'b10);
            if (prev_hs && !d_hs) fall = n;
            prev_hs = d_hs;
        end
        check("def next line 50 clk late", fall, 1106);
    endtask

    task automatic run_chk();
        c_rst_n = 1'b0; c_en = 1'b1; c_mode = 2'd2; c_solid = 8'hE0;
        repeat (3) @(negedge clk);
        c_rst_n = 1'b1;
        for (int n = 0; n < 37 * 1056; n++) begin
            @(negedge clk);
            if (c_de && c_y < 6'd40) c_frame[c_y][c_x] = c_rgb;
        end
    endtask

    task automatic run_sm();
        int bx_exp[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 11, 10, 9, 8};
        int by_exp[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        int fs_bad = 0, vs_low = 0, hs_low = 0;
        s_rst_n = 1'b0; s_en = 1'b1; s_mode = 2'd3; s_solid = 8'h5A;
        repeat (3) @(negedge clk);
        s_rst_n = 1'b1;
        for (int f = 0; f < 19; f++) begin
            int minx = 99, miny = 99, maxx = -1, maxy = -1, cnt = 0, bad = 0;
            for (int n = 0; n < 330; n++) begin
                @(negedge clk);
                if (s_fs != (n == 0)) fs_bad++;
                if (f == 0 && !s_vs) vs_low++;
                if (f == 0 && !s_hs) hs_low++;
                if (s_de) begin
                    if (f < 17) begin
                        if (s_rgb != 8'd0) begin
                            cnt++;
                            if (s_rgb != 8'h5A) bad++;
                            if (int'(s_x) < minx) minx = int'(s_x);
                            if (int'(s_y) < miny) miny = int'(s_y);
                            if (int'(s_x) > maxx) maxx = int'(s_x);
                            if (int'(s_y) > maxy) maxy = int'(s_y);
                        end
                    end else if (f == 17) begin
                        if (s_rgb != ((s_x[2] ^ s_y[2]) ? 8'h5A : 8'h00)) bad++;
                    end else begin
                        cnt++;
                        if (s_rgb != 8'h5A) bad++;
                    end
                end
                if (n == 100 && f == 16) s_mode = 2'd2;
                if (n == 100 && f == 17) s_mode = 2'd0;
            end
            if (f < 17)
                check($sformatf("small box frame %0d", f),
                      {8'(minx), 8'(miny), 8'(maxx), 8'(maxy), 8'(cnt), 8'(bad)},
                      {8'(bx_exp[f]), 8'(by_exp[f]), 8'(bx_exp[f] + 3), 8'(by_exp[f] + 3), 8'd16, 8'd0});
            else if (f == 17) check("small checker frame", bad, 0);
            else check("small solid frame", {cnt, bad}, {32'd192, 32'd0});
        end
        check("small frame_start period", fs_bad, 0);
        check("small sync low per frame", {vs_low, hs_low}, {32'd22, 32'd30});
    endtask

    initial begin
        bar_tbl = '{'{0, 0, 8'hFF}, '{99, 0, 8'hFF}, '{100, 0, 8'hFC}, '{200, 0, 8'h1F},
                    '{300, 0, 8'h1C}, '{400, 0, 8'hE3}, '{500, 0, 8'hE0}, '{600, 0, 8'h03},
                    '{699, 0, 8'h03}, '{700, 0, 8'h00}, '{799, 0, 8'h00}};
        chk_tbl = '{'{0, 0, 8'h00}, '{31, 0, 8'h00}, '{32, 0, 8'hE0}, '{64, 0, 8'h00},
                    '{0, 32, 8'hE0}, '{32, 32, 8'h00}, '{799, 34, 8'hE0}};
        for (int i = 0; i < 800; i++) begin
            d_line[i] = 8'h55;
            for (int j = 0; j < 40; j++) c_frame[j][i] = 8'h55;
        end
        fork
            run_def();
            run_chk();
            run_sm();
        join
        for (int i = 0; i < 11; i++)
            check($sformatf("bars x=%0d", bar_tbl[i].x), d_line[bar_tbl[i].x], bar_tbl[i].rgb);
        for (int i = 0; i < 7; i++)
            check($sformatf("checker (%0d,%0d)", chk_tbl[i].x, chk_tbl[i].y),
                  c_frame[chk_tbl[i].y][chk_tbl[i].x], chk_tbl[i].rgb);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
